// File: rtl/data_mem_responder.sv
// Byte-serial 256x8 data memory responder for the memory stage.
// Accepts one byte/halfword/word request at a time, moves one byte per
// transfer slot of 1+WAIT_STATES cycles (big-endian, address wraps mod 256),
// and reports completion with a one-cycle DONE pulse.
//
// Handshake: a request is taken in IDLE when EN=1 and SIZE is legal; BUSY is
// high combinationally in that cycle and for the whole access, so the
// pipeline holds its request stable (or not - inputs are ignored once taken)
// until the cycle after DONE, which is the earliest next acceptance.
module data_mem_responder #(
  parameter int WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        RW,
  input  logic [1:0]  SIZE,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

  state_t      state, state_nxt;
  logic [7:0]  mem [0:255];
  logic [7:0]  cur_addr;
  logic        rw_q;
  logic [1:0]  last_idx;
  logic [1:0]  byte_cnt;
  logic [2:0]  wait_cnt;
  logic [31:0] wdata;
  logic [23:0] rdata;
  logic        accept;
  logic        slot_end;
  logic        last_byte;
  logic [7:0]  rd_byte;

  assign accept    = (state == S_IDLE) && EN && (SIZE != 2'b11);
  assign slot_end  = (wait_cnt == WAIT_LAST);
  assign last_byte = (byte_cnt == last_idx);
  assign rd_byte   = mem[cur_addr];

  // State register: reset aborts any access in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: IDLE -> ACCESS on a legal request, ACCESS -> DONE after the
  // last byte's slot, DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ACCESS;
      S_ACCESS: if (slot_end && last_byte) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: BUSY covers the accept cycle and the whole ACCESS phase.
  always_comb begin
    BUSY      = accept || (state == S_ACCESS);
    DONE      = (state == S_DONE);
    state_dbg = state;
  end

  // Datapath: latch the request, step slot/byte counters, shift data, load DO.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cur_addr <= 8'h0;
      rw_q     <= 1'b0;
      last_idx <= 2'd0;
      byte_cnt <= 2'd0;
      wait_cnt <= 3'd0;
      wdata    <= 32'h0;
      rdata    <= 24'h0;
      DO       <= 32'h0;
      ERR      <= 1'b0;
    end else begin
      ERR <= (state == S_IDLE) && EN && (SIZE == 2'b11);
      if (accept) begin
        cur_addr <= ADDR;
        rw_q     <= RW;
        byte_cnt <= 2'd0;
        wait_cnt <= 3'd0;
        rdata    <= 24'h0;
        // Left-align the store data so the next byte is always wdata[31:24].
        case (SIZE)
          2'b00:   begin last_idx <= 2'd0; wdata <= {DI[7:0], 24'h0};  end
          2'b01:   begin last_idx <= 2'd1; wdata <= {DI[15:0], 16'h0}; end
          default: begin last_idx <= 2'd3; wdata <= DI;                end
        endcase
      end else if (state == S_ACCESS) begin
        if (slot_end) begin
          wait_cnt <= 3'd0;
          byte_cnt <= byte_cnt + 2'd1;
          cur_addr <= cur_addr + 8'd1;
          wdata    <= {wdata[23:0], 8'h0};
          rdata    <= {rdata[15:0], rd_byte};
          // Upper bytes come out zero because rdata starts cleared.
          if (last_byte && !rw_q) DO <= {rdata, rd_byte};
        end else begin
          wait_cnt <= wait_cnt + 3'd1;
        end
      end
    end
  end

  // Storage: written on the last cycle of a slot; never cleared by reset.
  always_ff @(posedge CLK) begin
    if ((state == S_ACCESS) && slot_end && rw_q) mem[cur_addr] <= wdata[31:24];
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT_STATES=0 and one with
// WAIT_STATES=2, selected by 'sel'. A byte-level memory model per instance
// predicts read data; predictions go into exp_q when a read is driven and are
// popped at the DUT's DONE pulse.
module tb_data_mem_responder;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST;
  logic        en;
  logic        RW;
  logic [1:0]  SIZE;
  logic [7:0]  ADDR;
  logic [31:0] DI;
  logic        sel;

  always #5 CLK = ~CLK;

  logic [31:0] do0, do2, do_m;
  logic        busy0, busy2, busy_m;
  logic        done0, done2, done_m;
  logic        err0, err2, err_m;
  logic [1:0]  st0, st2;
  logic        en0, en2;

  assign en0    = en & ~sel;
  assign en2    = en & sel;
  assign do_m   = sel ? do2   : do0;
  assign busy_m = sel ? busy2 : busy0;
  assign done_m = sel ? done2 : done0;
  assign err_m  = sel ? err2  : err0;

  data_mem_responder #(.WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST(RST), .EN(en0), .RW(RW), .SIZE(SIZE), .ADDR(ADDR), .DI(DI),
    .DO(do0), .BUSY(busy0), .DONE(done0), .ERR(err0), .state_dbg(st0)
  );

  data_mem_responder #(.WAIT_STATES(2)) dut2 (
    .CLK(CLK), .RST(RST), .EN(en2), .RW(RW), .SIZE(SIZE), .ADDR(ADDR), .DI(DI),
    .DO(do2), .BUSY(busy2), .DONE(done2), .ERR(err2), .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [7:0]  mdl [0:1][0:255];
  logic [31:0] last_do [0:1];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s sel=%0d got=%h exp=%h t=%0t", tag, sel, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_req(input logic w, input logic [1:0] sz, input logic [7:0] a,
                         input logic [31:0] d, input bit perturb);
    int          n, exp_lat, lat, busy_cnt, idx;
    bit          done_seen, err_seen;
    logic [31:0] rv, exp_v;
    idx     = sel ? 1 : 0;
    n       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_lat = n * (1 + (sel ? 2 : 0)) + 1;
    if (w) begin
      for (int i = 0; i < n; i++) mdl[idx][8'(a + i)] = d[8*(n-1-i) +: 8];
    end else begin
      rv = 32'h0;
      for (int i = 0; i < n; i++) rv = {rv[23:0], mdl[idx][8'(a + i)]};
      exp_q.push_back(rv);
    end
    @(negedge CLK);
    en = 1'b1; RW = w; SIZE = sz; ADDR = a; DI = d;
    #1;
    check("busy_accept", {31'h0, busy_m}, 32'd1);
    busy_cnt  = 1;
    lat       = 0;
    done_seen = 1'b0;
    err_seen  = 1'b0;
    @(posedge CLK);
    while (!done_seen && lat < 200) begin
      @(negedge CLK);
      lat++;
      if (err_m) err_seen = 1'b1;
      if (done_m) done_seen = 1'b1;
      else if (busy_m) busy_cnt++;
      if (!done_seen && perturb) begin
        en   = 1'($urandom_range(0, 1));
        ADDR = 8'($urandom);
        DI   = $urandom;
        RW   = 1'($urandom_range(0, 1));
        SIZE = 2'($urandom_range(0, 3));
      end else begin
        en = 1'b0;
      end
    end
    en = 1'b0;
    check("done_latency", lat, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
    check("busy_in_done", {31'h0, busy_m}, 32'd0);
    check("no_err_in_access", {31'h0, err_seen}, 32'd0);
    if (!w) begin
      exp_v = exp_q.pop_front();
      check("read_data", do_m, exp_v);
      last_do[idx] = exp_v;
    end else begin
      check("write_keeps_do", do_m, last_do[idx]);
    end
    @(negedge CLK);
    check("done_one_cycle", {31'h0, done_m}, 32'd0);
    check("do_hold", do_m, last_do[idx]);
  endtask

  task automatic illegal_req(input logic w, input logic [7:0] a, input logic [31:0] d);
    int idx;
    idx = sel ? 1 : 0;
    @(negedge CLK);
    en = 1'b1; RW = w; SIZE = 2'b11; ADDR = a; DI = d;
    #1;
    check("illegal_busy", {31'h0, busy_m}, 32'd0);
    @(negedge CLK);
    en = 1'b0;
    check("illegal_err", {31'h0, err_m}, 32'd1);
    check("illegal_busy_after", {31'h0, busy_m}, 32'd0);
    check("illegal_no_done", {31'h0, done_m}, 32'd0);
    check("illegal_do", do_m, last_do[idx]);
    @(negedge CLK);
    check("illegal_err_pulse", {31'h0, err_m}, 32'd0);
  endtask

  task automatic random_phase(input int count);
    for (int k = 0; k < 4; k++) run_req(1'b1, 2'd2, 8'(8'h80 + 4*k), $urandom, 1'b0);
    for (int k = 0; k < count; k++)
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
              8'(8'h80 + $urandom_range(0, 12)), $urandom, 1'($urandom_range(0, 1)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit done_in_rst;
    sel = 1'b0; en = 1'b0; RW = 1'b0; SIZE = 2'b00; ADDR = 8'h0; DI = 32'h0;
    RST = 1'b0;
    last_do[0] = 32'h0;
    last_do[1] = 32'h0;
    repeat (2) @(negedge CLK);
    check("rst_do0", do0, 32'h0);
    check("rst_do2", do2, 32'h0);
    check("rst_busy", {30'h0, busy0, busy2}, 32'h0);
    check("rst_done", {30'h0, done0, done2}, 32'h0);
    check("rst_err", {30'h0, err0, err2}, 32'h0);
    check("rst_state", {28'h0, st0, st2}, 32'h0);
    RST = 1'b1;

    // No wait states: word write/read, byte read, wrap-around halfword.
    run_req(1'b1, 2'd2, 8'h10, 32'hDEADBEEF, 1'b0);
    run_req(1'b0, 2'd2, 8'h10, 32'h0, 1'b0);
    check("word_read_literal", do0, 32'hDEADBEEF);
    run_req(1'b0, 2'd0, 8'h11, 32'h0, 1'b0);
    check("byte_read_literal", do0, 32'h000000AD);
    run_req(1'b1, 2'd1, 8'hFF, 32'h1234ABCD, 1'b0);
    run_req(1'b0, 2'd1, 8'hFF, 32'h0, 1'b0);
    check("half_wrap_literal", do0, 32'h0000ABCD);
    run_req(1'b0, 2'd0, 8'hFF, 32'h0, 1'b0);
    run_req(1'b0, 2'd0, 8'h00, 32'h0, 1'b0);
    check("wrap_byte00", do0, 32'h000000CD);

    // Illegal size, with write intent, leaves memory and DO alone.
    illegal_req(1'b1, 8'h10, 32'h0);
    run_req(1'b0, 2'd2, 8'h10, 32'h0, 1'b0);

    // Inputs wiggled throughout ACCESS must not alter the result.
    run_req(1'b0, 2'd2, 8'h10, 32'h0, 1'b1);
    check("perturbed_read", do0, 32'hDEADBEEF);

    // Reset in the middle of a word write.
    run_req(1'b1, 2'd2, 8'h20, 32'h11223344, 1'b0);
    @(negedge CLK);
    en = 1'b1; RW = 1'b1; SIZE = 2'd2; ADDR = 8'h20; DI = 32'hAABBCCDD;
    @(negedge CLK);
    en = 1'b0;
    done_in_rst = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (done0) done_in_rst = 1'b1;
    end
    RST = 1'b0;
    mdl[0][8'h20] = 8'hAA;
    mdl[0][8'h21] = 8'hBB;
    last_do[0] = 32'h0;
    last_do[1] = 32'h0;
    #1;
    check("midrst_do", do0, 32'h0);
    check("midrst_busy", {31'h0, busy0}, 32'h0);
    repeat (2) begin
      @(negedge CLK);
      if (done0) done_in_rst = 1'b1;
    end
    RST = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (done0) done_in_rst = 1'b1;
    end
    check("midrst_no_done", {31'h0, done_in_rst}, 32'h0);
    check("midrst_state", {30'h0, st0}, 32'h0);
    run_req(1'b0, 2'd2, 8'h20, 32'h0, 1'b0);
    check("midrst_partial", do0, 32'hAABB3344);

    random_phase(12);

    // Two wait states.
    sel = 1'b1;
    run_req(1'b1, 2'd0, 8'h40, 32'h0000005A, 1'b0);
    run_req(1'b0, 2'd0, 8'h40, 32'h0, 1'b0);
    check("ws2_byte_literal", do2, 32'h0000005A);
    run_req(1'b1, 2'd2, 8'hFE, 32'hCAFEF00D, 1'b0);
    run_req(1'b0, 2'd2, 8'hFE, 32'h0, 1'b1);
    check("ws2_word_wrap", do2, 32'hCAFEF00D);
    illegal_req(1'b0, 8'h40, 32'h0);
    random_phase(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 0: extra idle cycles inserted per byte transfer (0..7).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 EN  input  1  request strobe from memory stage (RAM_CTRL[0]).
REQ-005 RW  input  1  1 = write, 0 = read (RAM_CTRL[1]).
REQ-006 SIZE  input  2  00 byte, 01 halfword, 10 word, 11 illegal (RAM_CTRL[3:2]).
REQ-007 ADDR  input  8  byte address of first (most significant) byte.
REQ-008 DI  input  32  store data.
REQ-009 DO  output  32  load data, registered.
REQ-010 BUSY  output  1  pipeline stall request.
REQ-011 DONE  output  1  one-cycle completion pulse.
REQ-012 ERR  output  1  one-cycle illegal-size pulse.

Function
REQ-013 Storage SHALL be 256 x 8 bits, byte-serial, one byte moved per transfer slot.
REQ-014 FSM states SHALL be IDLE, ACCESS, DONE; no other reachable states.
REQ-015 In IDLE, EN=1 with SIZE!=11 SHALL accept: latch ADDR, RW, SIZE, DI; load byte count N (1/2/4); next state ACCESS.
REQ-016 BUSY SHALL be combinationally 1 in IDLE when a legal request is present, and 1 throughout ACCESS; 0 in DONE and otherwise.
REQ-017 In ACCESS each byte SHALL occupy 1+WAIT_STATES cycles; the byte is read/written on the last cycle of its slot.
REQ-018 After byte N-1 the FSM SHALL enter DONE for exactly one cycle (DONE=1), then return to IDLE.
REQ-019 Latency: acceptance at cycle 0, DONE asserted at cycle N*(1+WAIT_STATES)+1.
REQ-020 Requests SHALL NOT be accepted in ACCESS or DONE; EN, ADDR, RW, SIZE, DI changes there SHALL be ignored.
REQ-021 Byte i SHALL use address (ADDR+i) mod 256; wrap-around from 255 to 0 is legal.
REQ-022 Big-endian writes: word stores DI[31:24],DI[23:16],DI[15:8],DI[7:0] at A..A+3; halfword stores DI[15:8],DI[7:0] at A,A+1; byte stores DI[7:0] at A.
REQ-023 Reads: word DO = {m[A],m[A+1],m[A+2],m[A+3]}; halfword DO = {16'h0,m[A],m[A+1]}; byte DO = {24'h0,m[A]}.
REQ-024 DO SHALL update only when a read reaches DONE, and hold its value until the next read's DONE; writes SHALL leave DO unchanged.
REQ-025 In IDLE, EN=1 with SIZE=11 SHALL pulse ERR for the following cycle, assert no BUSY, access no memory, stay IDLE.
REQ-026 EN=0 in IDLE SHALL leave all outputs and memory unchanged.
REQ-027 Back-to-back requests: earliest second acceptance SHALL be the cycle after DONE.

Reset
REQ-028 RST=0 SHALL immediately force IDLE, BUSY=0, DONE=0, ERR=0, DO=32'h0, byte counter and wait counter 0.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 Reset mid-ACCESS SHALL abort: bytes already written remain, remaining bytes are not written, no DONE pulse.
REQ-031 First request SHALL be accepted on the first rising edge with RST=1 and EN=1.

Verification
REQ-032 WAIT_STATES=0: word write DI=32'hDEADBEEF ADDR=8'h10, then word read ADDR=8'h10 -> BUSY 5 cycles each, DONE at cycle 5, DO=32'hDEADBEEF; byte read 8'h11 -> DO=32'h000000AD.
REQ-033 Halfword write DI=32'h1234ABCD ADDR=8'hFF, halfword read ADDR=8'hFF -> m[FF]=AB, m[00]=CD, DO=32'h0000ABCD (wrap).
REQ-034 WAIT_STATES=2, byte read -> DONE exactly at cycle 4 after acceptance, BUSY high cycles 0..3.
REQ-035 SIZE=11, EN=1 in IDLE -> ERR=1 for one cycle, BUSY=0, DO unchanged, memory unchanged.
REQ-036 Word write 32'hAABBCCDD to 8'h20, RST low after second byte slot -> m[20]=AA, m[21]=BB, m[22],m[23] unchanged, DO=0, DONE never pulses.
REQ-037 Change ADDR/DI/EN during ACCESS of word read -> result identical to unperturbed run.
